// File: rtl/coord_sampler.sv
// coord_sampler: fetches an X then a Y value from an upstream random source,
// rejects out-of-range pairs and presents accepted pairs on a valid/ready port.
module coord_sampler #(
    parameter int unsigned X_MAX       = 640,
    parameter int unsigned Y_MAX       = 480,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        fetch,
    input  logic        rand_ack,
    input  logic [11:0] rand_in,
    output logic [11:0] coord_x,
    output logic [11:0] coord_y,
    output logic        coord_valid,
    input  logic        coord_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  reject_cnt
);

    localparam int unsigned W_COORD = 12;
    localparam int unsigned W_REJ   = 8;
    localparam int unsigned W_CNT   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    // The counter only ever holds 0..ACK_TIMEOUT-1; reaching the last value
    // without an ack is the timeout point.
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(ACK_TIMEOUT - 1);
    localparam logic [W_REJ-1:0] REJ_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_X = 3'd1,
        S_WAIT_X  = 3'd2,
        S_FETCH_Y = 3'd3,
        S_WAIT_Y  = 3'd4,
        S_CHECK   = 3'd5,
        S_VALID   = 3'd6
    } state_t;

    state_t               r_state;
    logic [W_CNT-1:0]     r_cnt;
    logic [W_COORD-1:0]   r_hold_x;
    logic [W_COORD-1:0]   r_hold_y;
    logic [W_COORD-1:0]   r_coord_x;
    logic [W_COORD-1:0]   r_coord_y;
    logic                 r_fetch;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_timeout;
    logic [W_REJ-1:0]     r_rej;

    state_t               w_state_nxt;
    logic [W_CNT-1:0]     w_cnt_nxt;
    logic [W_COORD-1:0]   w_hold_x_nxt;
    logic [W_COORD-1:0]   w_hold_y_nxt;
    logic [W_COORD-1:0]   w_coord_x_nxt;
    logic [W_COORD-1:0]   w_coord_y_nxt;
    logic                 w_fetch_nxt;
    logic                 w_valid_nxt;
    logic                 w_busy_nxt;
    logic                 w_timeout_nxt;
    logic [W_REJ-1:0]     w_rej_nxt;
    logic                 w_in_range;

    assign w_in_range = (32'(r_hold_x) < X_MAX) && (32'(r_hold_y) < Y_MAX);

    // Next-state and next-register logic; flag outputs are decoded from the
    // next state so they line up with the state register.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hold_x_nxt  = r_hold_x;
        w_hold_y_nxt  = r_hold_y;
        w_coord_x_nxt = r_coord_x;
        w_coord_y_nxt = r_coord_y;
        w_timeout_nxt = r_timeout;
        w_rej_nxt     = r_rej;

        case (r_state)
            S_IDLE: begin
                if (req) w_state_nxt = S_FETCH_X;
            end
            S_FETCH_X: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_X;
            end
            S_WAIT_X: begin
                if (rand_ack) begin
                    w_hold_x_nxt = rand_in;
                    w_state_nxt  = S_FETCH_Y;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + W_CNT'(1);
                end
            end
            S_FETCH_Y: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                if (rand_ack) begin
                    w_hold_y_nxt = rand_in;
                    w_state_nxt  = S_CHECK;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + W_CNT'(1);
                end
            end
            S_CHECK: begin
                if (w_in_range) begin
                    w_coord_x_nxt = r_hold_x;
                    w_coord_y_nxt = r_hold_y;
                    w_state_nxt   = S_VALID;
                end else begin
                    if (r_rej != REJ_MAX) w_rej_nxt = r_rej + W_REJ'(1);
                    w_state_nxt = S_FETCH_X;
                end
            end
            S_VALID: begin
                if (coord_ready) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_fetch_nxt = (w_state_nxt == S_FETCH_X) || (w_state_nxt == S_FETCH_Y);
        w_valid_nxt = (w_state_nxt == S_VALID);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hold_x  <= '0;
            r_hold_y  <= '0;
            r_coord_x <= '0;
            r_coord_y <= '0;
            r_fetch   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_rej     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hold_x  <= w_hold_x_nxt;
            r_hold_y  <= w_hold_y_nxt;
            r_coord_x <= w_coord_x_nxt;
            r_coord_y <= w_coord_y_nxt;
            r_fetch   <= w_fetch_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_rej     <= w_rej_nxt;
        end
    end

    assign fetch       = r_fetch;
    assign coord_x     = r_coord_x;
    assign coord_y     = r_coord_y;
    assign coord_valid = r_valid;
    assign busy        = r_busy;
    assign timeout_err = r_timeout;
    assign reject_cnt  = r_rej;

endmodule

// File: doc/coord_sampler.md
COORD_SAMPLER -- requirements
Module: coord_sampler

Interface
REQ-001 The block SHALL have parameter X_MAX, default 640, meaning the exclusive upper bound for coord_x.
REQ-002 The block SHALL have parameter Y_MAX, default 480, meaning the exclusive upper bound for coord_y.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum number of cycles to wait for rand_ack.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, 1 bit: request a new (x,y) pair; sampled only in IDLE.
REQ-007 The block SHALL have port fetch, output, 1 bit: one-cycle pulse requesting the next LFSR value.
REQ-008 The block SHALL have port rand_ack, input, 1 bit: upstream acknowledge; rand_in is valid in the same cycle.
REQ-009 The block SHALL have port rand_in, input, 12 bits: upstream pseudo-random value.
REQ-010 The block SHALL have port coord_x, output, 12 bits: accepted X coordinate.
REQ-011 The block SHALL have port coord_y, output, 12 bits: accepted Y coordinate.
REQ-012 The block SHALL have port coord_valid, output, 1 bit: the coord pair is valid.
REQ-013 The block SHALL have port coord_ready, input, 1 bit: the consumer accepts the pair.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port timeout_err, output, 1 bit: sticky flag set when an ack timeout occurs.
REQ-016 The block SHALL have port reject_cnt, output, 8 bits: saturating count of rejected pairs since reset.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH_X, WAIT_X, FETCH_Y, WAIT_Y, CHECK, and VALID.
REQ-018 In IDLE, req=1 SHALL move the FSM to FETCH_X on the next edge; otherwise it stays in IDLE.
REQ-019 fetch SHALL be high only in FETCH_X and FETCH_Y, for exactly one cycle each, and each is followed unconditionally by WAIT_X or WAIT_Y respectively.
REQ-020 In WAIT_X, rand_ack=1 SHALL capture rand_in into the X holding register and move to FETCH_Y.
REQ-021 In WAIT_Y, rand_ack=1 SHALL capture rand_in into the Y holding register and move to CHECK.
REQ-022 A wait counter SHALL clear on entry to each WAIT state and increment each cycle without ack.
REQ-023 If the wait counter reaches ACK_TIMEOUT, the block SHALL set timeout_err=1 and go to IDLE, with coord outputs left unchanged.
REQ-024 CHECK SHALL take one cycle: if X<X_MAX and Y<Y_MAX (unsigned 12-bit), the FSM goes to VALID; otherwise it goes to FETCH_X and increments reject_cnt, saturating at 255.
REQ-025 On the transition into VALID, coord_x and coord_y SHALL load from the holding registers.
REQ-026 coord_valid SHALL be high exactly while in VALID.
REQ-027 coord_x, coord_y, and coord_valid SHALL be stable until coord_valid&coord_ready is seen.
REQ-028 In VALID, coord_ready=1 SHALL move the FSM to IDLE on that edge.
REQ-029 req asserted outside IDLE SHALL be ignored and not queued.
REQ-030 rand_ack outside the WAIT states SHALL be ignored.
REQ-031 Minimum latency from req to coord_valid, with rand_ack returned one cycle after fetch, SHALL be 6 cycles.
REQ-032 timeout_err SHALL clear only by reset; a new req after a timeout SHALL be serviced normally.

Reset
REQ-033 While reset=1, asynchronously: state=IDLE, fetch=0, coord_valid=0, coord_x=0, coord_y=0, busy=0, timeout_err=0, reject_cnt=0, and the wait counter and holding registers are 0.
REQ-034 Reset asserted mid-operation SHALL abort immediately with no fetch pulse emitted after deassertion until a new req.

Verification
REQ-035 Scenario: req pulse; the model acks each fetch one cycle later with 0x123 then 0x0A0 -> coord_x=0x123, coord_y=0x0A0, coord_valid 6 cycles after req, and exactly two fetch pulses.
REQ-036 Scenario: acks return 0x300 (768) then 0x010, then 0x050 then 0x020 -> reject_cnt=1, four fetch pulses, coord=(0x050,0x020).
REQ-037 Scenario: X=0x27F, Y=0x1DF accepted; X=0x280 rejected; Y=0x1E0 rejected -> exercises the exact bounds.
REQ-038 Scenario: the model never acks -> timeout_err=1 after 15 wait cycles, busy=0, coord_valid=0; a subsequent req with a normal model completes.
REQ-039 Scenario: coord_ready held low 10 cycles in VALID while req toggles -> outputs stable, no fetch pulses; coord_ready=1 -> IDLE next cycle.
REQ-040 Scenario: reset asserted in WAIT_Y -> all outputs reach their reset values without a clock edge; no fetch pulse occurs afterwards until req.
